// File: rtl/pipeline_validity_chain.sv
// Valid-bit chain for every pipeline stage, fetch (stage 0) to retire.
// Optional perf counters when `VCHAIN_PERF_CNT_EN is defined.
module pipeline_validity_chain #(
  parameter int  NUM_STAGES = 5,
  parameter int  CNT_W      = 32,
  localparam int OCC_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  fetch_valid_i,
  input  logic [NUM_STAGES-1:0] stall_i,
  input  logic [NUM_STAGES-1:0] squash_i,
  output logic [NUM_STAGES-1:0] valid_o,
  output logic [NUM_STAGES-1:0] advance_o,
  output logic                  retire_o,
  output logic [OCC_W-1:0]      occupancy_o,
  output logic                  empty_o
`ifdef VCHAIN_PERF_CNT_EN
  ,
  input  logic                  perf_clr_i,
  output logic [CNT_W-1:0]      retired_cnt_o,
  output logic [CNT_W-1:0]      squashed_cnt_o,
  output logic [CNT_W-1:0]      bubble_cnt_o
`endif
);

  logic [NUM_STAGES-1:0] v_q;
  logic [NUM_STAGES-1:0] v_d;
  logic [NUM_STAGES-1:0] hold;

  if (NUM_STAGES < 2 || NUM_STAGES > 16 || CNT_W < 1) begin : g_bad_cfg
    $error("pipeline_validity_chain: illegal parameters");
  end

  // A stall freezes its own stage and everything younger.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    assign hold[k] = |stall_i[NUM_STAGES-1:k];
    if (k == 0) begin : g_head
      assign v_d[k] = hold[k] ? valid_o[k] : fetch_valid_i;
    end else begin : g_body
      assign v_d[k] = hold[k]         ? valid_o[k] :
                      stall_i[k-1]    ? 1'b0       :
                                        valid_o[k-1];
    end
  end

  assign advance_o = ~hold;
  assign valid_o   = v_q & ~squash_i;
  assign retire_o  = valid_o[NUM_STAGES-1] & ~stall_i[NUM_STAGES-1];
  assign empty_o   = ~|valid_o;

  always_comb begin
    occupancy_o = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      occupancy_o = occupancy_o + OCC_W'(valid_o[k]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

`ifdef VCHAIN_PERF_CNT_EN
  logic [OCC_W-1:0] sq_pop;

  always_comb begin
    sq_pop = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      sq_pop = sq_pop + OCC_W'(v_q[k] & squash_i[k]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retired_cnt_o  <= '0;
      squashed_cnt_o <= '0;
      bubble_cnt_o   <= '0;
    end else if (perf_clr_i) begin
      retired_cnt_o  <= '0;
      squashed_cnt_o <= '0;
      bubble_cnt_o   <= '0;
    end else begin
      retired_cnt_o  <= retired_cnt_o + CNT_W'(retire_o);
      squashed_cnt_o <= squashed_cnt_o + CNT_W'(sq_pop);
      bubble_cnt_o   <= bubble_cnt_o + CNT_W'(~retire_o);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_validity_chain.sv
// Directed testbench for pipeline_validity_chain (NUM_STAGES = 5).
// Perf counter scenario runs only when VCHAIN_PERF_CNT_EN is defined.
module tb_pipeline_validity_chain;

  logic       clk;
  logic       rst_n;
  logic       fetch;
  logic [4:0] stall;
  logic [4:0] squash;
  logic [4:0] valid;
  logic [4:0] adv;
  logic       retire;
  logic [2:0] occ;
  logic       empty;
`ifdef VCHAIN_PERF_CNT_EN
  logic        perf_clr;
  logic [31:0] ret_cnt;
  logic [31:0] sq_cnt;
  logic [31:0] bub_cnt;
`endif

  int checks;
  int errors;

  pipeline_validity_chain #(
    .NUM_STAGES(5),
    .CNT_W(32)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .fetch_valid_i(fetch),
    .stall_i(stall),
    .squash_i(squash),
    .valid_o(valid),
    .advance_o(adv),
    .retire_o(retire),
    .occupancy_o(occ),
    .empty_o(empty)
`ifdef VCHAIN_PERF_CNT_EN
    ,
    .perf_clr_i(perf_clr),
    .retired_cnt_o(ret_cnt),
    .squashed_cnt_o(sq_cnt),
    .bubble_cnt_o(bub_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic f, input logic [4:0] st,
                      input logic [4:0] sq);
    @(negedge clk);
    fetch  = f;
    stall  = st;
    squash = sq;
    #1;
  endtask

  task automatic test_reset;
    checks++;
    if (valid !== 5'b0) begin
      errors++;
      $display("FAIL reset valid: got %b exp 00000", valid);
    end
    checks++;
    if (empty !== 1'b1 || occ !== 3'd0 || retire !== 1'b0) begin
      errors++;
      $display("FAIL reset flags: got empty=%b occ=%0d ret=%b exp 1 0 0",
               empty, occ, retire);
    end
    checks++;
    if (adv !== 5'b11111) begin
      errors++;
      $display("FAIL reset advance: got %b exp 11111", adv);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency;
    logic [4:0] one;
    logic [4:0] exp;
    one = 5'b00001;
    step(1'b1, 5'b0, 5'b0);
    checks++;
    if (valid !== 5'b0) begin
      errors++;
      $display("FAIL latency t0 valid: got %b exp 00000", valid);
    end
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 5'b0, 5'b0);
      exp = (i <= 5) ? (one << (i - 1)) : 5'b0;
      checks++;
      if (valid !== exp) begin
        errors++;
        $display("FAIL latency t%0d valid: got %b exp %b", i, valid, exp);
      end
      checks++;
      if (retire !== (i == 5)) begin
        errors++;
        $display("FAIL latency t%0d retire: got %b exp %b",
                 i, retire, (i == 5));
      end
    end
  endtask

  task automatic test_stall;
    logic [4:0] st [6];
    logic [4:0] ev [6];
    logic       er [6];
    st = '{5'b00100, 5'b00100, 5'b00100, 5'b0, 5'b0, 5'b0};
    ev = '{5'b11111, 5'b10111, 5'b00111, 5'b00111, 5'b01111, 5'b11111};
    er = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    repeat (5) step(1'b1, 5'b0, 5'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, st[i], 5'b0);
      checks++;
      if (valid !== ev[i] || retire !== er[i]) begin
        errors++;
        $display("FAIL stall c%0d: got valid=%b ret=%b exp %b %b",
                 i, valid, retire, ev[i], er[i]);
      end
      if (i == 0) begin
        checks++;
        if (adv !== 5'b11000) begin
          errors++;
          $display("FAIL stall advance: got %b exp 11000", adv);
        end
      end
    end
  endtask

  task automatic test_squash_stall;
    logic [4:0] st [7];
    logic [4:0] sq [7];
    logic [4:0] ev [7];
    logic       er [7];
    st = '{5'b00100, 5'b00100, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0};
    sq = '{5'b00010, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0};
    ev = '{5'b11101, 5'b10101, 5'b00101, 5'b01011,
           5'b10111, 5'b01111, 5'b11111};
    er = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, st[i], sq[i]);
      checks++;
      if (valid !== ev[i] || retire !== er[i]) begin
        errors++;
        $display("FAIL squash_stall c%0d: got valid=%b ret=%b exp %b %b",
                 i, valid, retire, ev[i], er[i]);
      end
    end
  endtask

  task automatic test_squash_multi;
    step(1'b1, 5'b0, 5'b00111);
    checks++;
    if (valid !== 5'b11000 || occ !== 3'd2) begin
      errors++;
      $display("FAIL squash_multi same: got valid=%b occ=%0d exp 11000 2",
               valid, occ);
    end
    step(1'b0, 5'b0, 5'b0);
    checks++;
    if (valid !== 5'b10001 || occ !== 3'd2) begin
      errors++;
      $display("FAIL squash_multi next: got valid=%b occ=%0d exp 10001 2",
               valid, occ);
    end
  endtask

  task automatic test_squash_all_stall;
    repeat (5) step(1'b1, 5'b0, 5'b0);
    step(1'b1, 5'b10000, 5'b11111);
    checks++;
    if (valid !== 5'b0 || empty !== 1'b1 || retire !== 1'b0) begin
      errors++;
      $display("FAIL kill_all same: got valid=%b empty=%b ret=%b exp 0 1 0",
               valid, empty, retire);
    end
    checks++;
    if (adv !== 5'b00000 || occ !== 3'd0) begin
      errors++;
      $display("FAIL kill_all adv/occ: got %b %0d exp 00000 0", adv, occ);
    end
    step(1'b1, 5'b10000, 5'b0);
    checks++;
    if (valid !== 5'b0) begin
      errors++;
      $display("FAIL kill_all held: got %b exp 00000", valid);
    end
    step(1'b1, 5'b0, 5'b0);
    checks++;
    if (valid !== 5'b0) begin
      errors++;
      $display("FAIL kill_all release: got %b exp 00000", valid);
    end
    step(1'b0, 5'b0, 5'b0);
    checks++;
    if (valid !== 5'b00001) begin
      errors++;
      $display("FAIL kill_all refill: got %b exp 00001", valid);
    end
    repeat (6) step(1'b0, 5'b0, 5'b0);
  endtask

  task automatic test_reset_mid;
    repeat (4) step(1'b1, 5'b0, 5'b0);
    step(1'b0, 5'b0, 5'b0);
    checks++;
    if (valid !== 5'b01111 || occ !== 3'd4) begin
      errors++;
      $display("FAIL rst_mid pre: got valid=%b occ=%0d exp 01111 4",
               valid, occ);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid !== 5'b0 || empty !== 1'b1 || occ !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid async: got valid=%b empty=%b occ=%0d exp 0 1 0",
               valid, empty, occ);
    end
    checks++;
    if (retire !== 1'b0 || adv !== 5'b11111) begin
      errors++;
      $display("FAIL rst_mid ret/adv: got %b %b exp 0 11111", retire, adv);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_latency();
  endtask

`ifdef VCHAIN_PERF_CNT_EN
  task automatic test_perf;
    logic [4:0] sq;
    perf_clr = 1'b1;
    step(1'b0, 5'b0, 5'b0);
    perf_clr = 1'b0;
    checks++;
    if (ret_cnt !== 32'd0 || sq_cnt !== 32'd0 || bub_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf clr0: got %0d %0d %0d exp 0 0 0",
               ret_cnt, sq_cnt, bub_cnt);
    end
    for (int i = 1; i <= 10; i++) begin
      sq = (i == 6) ? 5'b00100 : (i == 8) ? 5'b01000 : 5'b0;
      step(1'b1, 5'b0, sq);
    end
    repeat (3) step(1'b0, 5'b00001, 5'b0);
    repeat (10) step(1'b0, 5'b0, 5'b0);
    checks++;
    if (ret_cnt !== 32'd8) begin
      errors++;
      $display("FAIL perf retired: got %0d exp 8", ret_cnt);
    end
    checks++;
    if (sq_cnt !== 32'd2) begin
      errors++;
      $display("FAIL perf squashed: got %0d exp 2", sq_cnt);
    end
    perf_clr = 1'b1;
    step(1'b0, 5'b0, 5'b0);
    perf_clr = 1'b0;
    checks++;
    if (ret_cnt !== 32'd0 || sq_cnt !== 32'd0 || bub_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf clr1: got %0d %0d %0d exp 0 0 0",
               ret_cnt, sq_cnt, bub_cnt);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    fetch  = 1'b0;
    stall  = 5'b0;
    squash = 5'b0;
`ifdef VCHAIN_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    #1;
    test_reset();
    test_latency();
    test_stall();
    test_squash_stall();
    test_squash_multi();
    test_squash_all_stall();
    test_reset_mid();
`ifdef VCHAIN_PERF_CNT_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
